// File: rtl/mem_wb_pkg.sv
// Shared pipeline constants for the MEM/WB boundary: bus types, load-op codes,
// stall-vector bit positions and the registered WB state record.
package mem_wb_pkg;

  localparam int RegWidth     = 32;
  localparam int RegAddrWidth = 5;

  typedef logic [RegWidth-1:0]     reg_bus_t;
  typedef logic [RegAddrWidth-1:0] reg_addr_bus_t;

  localparam reg_bus_t ZeroWord    = '0;
  localparam logic     WriteEnable = 1'b1;
  localparam logic     RstEnable   = 1'b1;

  // Stall vector bit positions
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  typedef enum logic [2:0] {
    LOAD_NONE = 3'd0,
    LOAD_LB   = 3'd1,
    LOAD_LBU  = 3'd2,
    LOAD_LH   = 3'd3,
    LOAD_LHU  = 3'd4,
    LOAD_LW   = 3'd5,
    LOAD_RSV6 = 3'd6,
    LOAD_RSV7 = 3'd7
  } load_op_e;

  typedef struct packed {
    reg_addr_bus_t wd;
    logic          wreg;
    reg_bus_t      data;
    load_op_e      load_op;
    logic [1:0]    load_off;
    logic          whilo;
    reg_bus_t      hi;
    reg_bus_t      lo;
  } wb_state_t;

endpackage

// File: rtl/mem_wb_load_align.sv
// Combinational load lane select and sign/zero extension: (raw, op, offset) -> word.
// Zero latency; no flow control.
module load_align
  import mem_wb_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] raw_i,
  input  load_op_e    op_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [1:0]  byte_idx;
  logic        hw_idx;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // byte_idx/hw_idx count lanes up from bit 0; big-endian offsets count down
    byte_idx = BIG_ENDIAN ? ~off_i : off_i;
    hw_idx   = BIG_ENDIAN ? ~off_i[1] : off_i[1];

    case (byte_idx)
      2'd0:    byte_sel = raw_i[7:0];
      2'd1:    byte_sel = raw_i[15:8];
      2'd2:    byte_sel = raw_i[23:16];
      default: byte_sel = raw_i[31:24];
    endcase

    half_sel = hw_idx ? raw_i[31:16] : raw_i[15:0];

    data_o = raw_i;
    case (op_i)
      LOAD_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: data_o = {24'd0, byte_sel};
      LOAD_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: data_o = {16'd0, half_sel};
      default:  data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register; one-cycle latency, wb_wdata extended from registered state only.
// Stall: MEM stalled + WB running inserts a bubble; both stalled holds; flush clears.
module mem_wb
  import mem_wb_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_load_op,
  input  logic [1:0]  mem_load_off,
  input  logic        mem_whilo,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        wb_whilo,
  output logic [31:0] wb_hi,
  output logic [31:0] wb_lo
);

  wb_state_t state_q, state_d;

  // Lower stall bits belong to earlier stages.
  logic unused_stall;
  assign unused_stall = ^stall[3:0];

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = '0;
    end else if (stall[STALL_MEM] && !stall[STALL_WB]) begin
      state_d = '0;
    end else if (!stall[STALL_MEM]) begin
      state_d = '{wd:       mem_wd,
                  wreg:     mem_wreg,
                  data:     mem_wdata,
                  load_op:  load_op_e'(mem_load_op),
                  load_off: mem_load_off,
                  whilo:    mem_whilo,
                  hi:       mem_hi,
                  lo:       mem_lo};
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  load_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_load_align (
    .raw_i (state_q.data),
    .op_i  (state_q.load_op),
    .off_i (state_q.load_off),
    .data_o(wb_wdata)
  );

  assign wb_wd    = state_q.wd;
  assign wb_wreg  = state_q.wreg;
  assign wb_whilo = state_q.whilo;
  assign wb_hi    = state_q.hi;
  assign wb_lo    = state_q.lo;

endmodule

// File: tb/tb_mem_wb.sv
// Bench for mem_wb: directed scenarios plus randomized traffic against a
// field-level reference model of the WB register and load extension.
module tb_mem_wb;

  localparam bit BE = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_load_op;
  logic [1:0]  mem_load_off;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: what WB should currently hold
  logic [4:0]  m_wd;
  logic        m_wreg;
  logic [31:0] m_data;
  logic [2:0]  m_op;
  logic [1:0]  m_off;
  logic        m_whilo;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mem_wb #(.BIG_ENDIAN(BE)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_load_op(mem_load_op), .mem_load_off(mem_load_off),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo)
  );

  always #5 clk = ~clk;

  // MEM running while WB is stalled is a control-unit bug.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(!stall[4] && stall[5]))
        else $error("illegal stall combination %b", stall);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_wdata(input logic [31:0] w, input logic [2:0] op,
                                            input logic [1:0] off);
    int          sh_b, sh_h;
    logic [31:0] b, h;
    sh_b = BE ? 8 * (3 - int'(off)) : 8 * int'(off);
    sh_h = BE ? 16 * (1 - int'(off[1])) : 16 * int'(off[1]);
    b = (w >> sh_b) & 32'h0000_00FF;
    h = (w >> sh_h) & 32'h0000_FFFF;
    case (op)
      3'd1:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  task automatic model_clear();
    m_wd = '0; m_wreg = 1'b0; m_data = '0; m_op = '0; m_off = '0;
    m_whilo = 1'b0; m_hi = '0; m_lo = '0;
  endtask

  // One clock: update model from the inputs present at the edge, then settle.
  task automatic cycle();
    @(posedge clk);
    if (rst || flush || (stall[4] && !stall[5])) begin
      model_clear();
    end else if (!stall[4]) begin
      m_wd = mem_wd; m_wreg = mem_wreg; m_data = mem_wdata; m_op = mem_load_op;
      m_off = mem_load_off; m_whilo = mem_whilo; m_hi = mem_hi; m_lo = mem_lo;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/wd"},    32'(wb_wd),    32'(m_wd));
    chk({tag, "/wreg"},  32'(wb_wreg),  32'(m_wreg));
    chk({tag, "/wdata"}, wb_wdata,      ref_wdata(m_data, m_op, m_off));
    chk({tag, "/whilo"}, 32'(wb_whilo), 32'(m_whilo));
    chk({tag, "/hi"},    wb_hi,         m_hi);
    chk({tag, "/lo"},    wb_lo,         m_lo);
  endtask

  task automatic rand_inputs();
    mem_wd       = 5'($urandom);
    mem_wreg     = 1'($urandom);
    mem_wdata    = $urandom;
    mem_load_op  = 3'($urandom);
    mem_load_off = 2'($urandom);
    mem_whilo    = 1'($urandom);
    mem_hi       = $urandom;
    mem_lo       = $urandom;
  endtask

  task automatic set_in(input logic [4:0] wd, input logic wreg, input logic [31:0] data,
                        input logic [2:0] op, input logic [1:0] off);
    mem_wd = wd; mem_wreg = wreg; mem_wdata = data; mem_load_op = op; mem_load_off = off;
    mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;
  endtask

  logic [2:0]  tab_op  [6] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd5};
  logic [1:0]  tab_off [6] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd3};
  logic [31:0] tab_exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F,
                               32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

  initial begin
    model_clear();
    rst = 1'b1; stall = '0; flush = 1'b0;
    rand_inputs();

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      cycle();
      rand_inputs();
    end
    check_all("reset");
    chk("reset_wdata_zero", wb_wdata, 32'h0);

    rst = 1'b0;
    set_in(5'd5, 1'b1, 32'h1234_5678, 3'd0, 2'd0);
    cycle();
    check_all("first");
    chk("first_wdata", wb_wdata, 32'h1234_5678);
    chk("first_wd", 32'(wb_wd), 32'd5);

    // Full op/offset sweep
    for (int op = 1; op <= 4; op++) begin
      for (int off = 0; off < 4; off++) begin
        set_in(5'd3, 1'b1, 32'h80FF_7F01, 3'(op), 2'(off));
        cycle();
        check_all("sweep");
      end
    end
    for (int i = 0; i < 6; i++) begin
      set_in(5'd3, 1'b1, 32'h80FF_7F01, tab_op[i], tab_off[i]);
      cycle();
      chk("ext_table", wb_wdata, tab_exp[i]);
    end

    // Hold under full stall
    set_in(5'd7, 1'b1, 32'h0000_00AA, 3'd0, 2'd0);
    cycle();
    stall = 6'b110000;
    set_in(5'd9, 1'b1, 32'h5555_5555, 3'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_wd", 32'(wb_wd), 32'd7);
      chk("hold_wdata", wb_wdata, 32'h0000_00AA);
      check_all("hold");
    end

    // Bubble
    stall = 6'b010000;
    mem_wreg = 1'b1; mem_whilo = 1'b1;
    cycle();
    chk("bubble_wreg", 32'(wb_wreg), 32'd0);
    chk("bubble_wd", 32'(wb_wd), 32'd0);
    chk("bubble_wdata", wb_wdata, 32'd0);
    chk("bubble_whilo", 32'(wb_whilo), 32'd0);

    // Flush beats stall
    stall = '0;
    set_in(5'd12, 1'b1, 32'hCAFE_F00D, 3'd0, 2'd0);
    cycle();
    chk("pre_flush_wreg", 32'(wb_wreg), 32'd1);
    flush = 1'b1; stall = 6'b110000;
    cycle();
    check_all("flush");
    chk("flush_wreg", 32'(wb_wreg), 32'd0);
    flush = 1'b0; stall = '0;
    set_in(5'd13, 1'b1, 32'h0BAD_BEEF, 3'd0, 2'd0);
    cycle();
    chk("post_flush_wdata", wb_wdata, 32'h0BAD_BEEF);

    // HI/LO then back-to-back captures
    set_in(5'd0, 1'b0, 32'h0, 3'd0, 2'd0);
    mem_whilo = 1'b1; mem_hi = 32'hDEAD_0000; mem_lo = 32'h0000_BEEF;
    cycle();
    chk("hilo_whilo", 32'(wb_whilo), 32'd1);
    chk("hilo_hi", wb_hi, 32'hDEAD_0000);
    chk("hilo_lo", wb_lo, 32'h0000_BEEF);
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      cycle();
      check_all("b2b");
      chk("b2b_hi", wb_hi, mem_hi);
    end

    // Randomized traffic with legal stall patterns, flushes and resets
    for (int i = 0; i < 500; i++) begin
      int r;
      rand_inputs();
      r = int'($urandom_range(0, 9));
      stall = (r < 6) ? 6'b000000 : (r < 8) ? 6'b110000 : 6'b010000;
      stall[3:0] = 4'($urandom);
      flush = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 29) == 0);
      cycle();
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb.md
Name: mem_wb

Overview:
- Final pipeline register between the memory-access stage and write-back.
- Latches the MEM-stage result and produces the register-file write port (we/waddr/wdata) and the HI/LO write port.
- Performs load-data sign/zero extension and byte/halfword lane selection in WB, so the register file always receives final architectural data.
- Obeys the central stall vector and the pipeline flush from the control unit.

Parameters:
- BIG_ENDIAN, 1, byte lane order for sub-word loads. 1: offset 0 = bits[31:24]. 0: offset 0 = bits[7:0].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset; clock clk
- stall  in  6  pipeline stall vector; bit4 = MEM stalled, bit5 = WB stalled
- flush  in  1  exception/pipeline flush
- mem_wd  in  5  destination register address
- mem_wreg  in  1  destination write enable
- mem_wdata  in  32  ALU result or raw loaded word
- mem_load_op  in  3  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6/7 reserved
- mem_load_off  in  2  byte offset of the load address
- mem_whilo  in  1  HI/LO write enable
- mem_hi  in  32  HI value
- mem_lo  in  32  LO value
- wb_wd  out  5  to regfile waddr
- wb_wreg  out  1  to regfile we
- wb_wdata  out  32  to regfile wdata (after extension)
- wb_whilo  out  1  HI/LO write enable
- wb_hi  out  32  HI value
- wb_lo  out  32  LO value

Behaviour:
- Internal registered state: wd, wreg, raw data, load_op, load_off, whilo, hi, lo.
- Update priority at posedge clk:
  - rst: all state cleared to 0.
  - flush: all state cleared to 0.
  - stall[4]=1 and stall[5]=0: bubble. All state cleared to 0, so no write is performed.
  - stall[4]=0: capture all mem_* inputs.
  - Otherwise (stall[4]=1, stall[5]=1): hold.
- stall[4]=0 with stall[5]=1 is an illegal control combination. Capture takes effect; the assertion fires in the bench.
- Latency: one cycle from the mem_* inputs to the wb_* outputs.
- wb_wd, wb_wreg, wb_whilo, wb_hi and wb_lo are direct register outputs.
- wb_wdata is combinational from registered state only. It has no combinational path from any mem_* input.
- Load extension, with byte b = lane(load_off) and halfword h = lane(load_off[1]); load_off[0] is ignored for halfwords:
  - op0: raw word.
  - op1: sign-extend b.
  - op2: zero-extend b.
  - op3: sign-extend h.
  - op4: zero-extend h.
  - op5: raw word; offset is ignored.
  - op6/7: treated as op0.
- Lane selection with BIG_ENDIAN=1:
  - Offsets 0/1/2/3 select bits [31:24]/[23:16]/[15:8]/[7:0].
  - Halfword offset[1]=0 selects [31:16]; offset[1]=1 selects [15:0].
  - BIG_ENDIAN=0 mirrors this mapping.
- Address 0 writes are passed through unchanged. Discarding them is the register file's job.
- wb_wdata is 0 whenever wb_wreg=0 after reset, flush or a bubble. No write-enable gating is applied to captured data.
- Reset asserted mid-stall clears the state. The first capture after reset occurs on the first edge with rst=0 and stall[4]=0.
- Flush in the same cycle as a stall: flush wins.
- All outputs reset to 0.

Decomposition:
- Shared constants go in the global define header:
  - LoadOpBus 2:0, with named LOAD_NONE/LB/LBU/LH/LHU/LW codes.
  - Stall bit indices STALL_MEM=4 and STALL_WB=5.
  - Existing RegBus, RegAddrBus, ZeroWord, WriteEnable and RstEnable.
- One natural sub-module, load_align: purely combinational (raw word, op, offset) -> extended word. It is reused by any future store/load unit.

Test Plan:
- rst=1 for 2 cycles, random inputs -> all wb_* outputs = 0. Release with mem_wd=5, mem_wreg=1, mem_wdata=0x12345678, op0 -> next cycle wb_wd=5, wb_wreg=1, wb_wdata=0x12345678.
- mem_wdata=0x80FF7F01, sweep op1..op4 and offsets 0..3 (BIG_ENDIAN=1):
  - LB off0 -> 0xFFFFFF80.
  - LBU off0 -> 0x00000080.
  - LB off2 -> 0x0000007F.
  - LH off0 -> 0xFFFF80FF.
  - LHU off2 -> 0x00007F01.
  - LW off3 -> 0x80FF7F01.
- Capture wd=7, data=0xAA; next cycle stall=6'b110000 for 3 cycles with new inputs (wd=9) -> outputs hold wd=7, data=0xAA throughout.
- stall=6'b010000 for 1 cycle with mem_wreg=1 -> next cycle wb_wreg=0, wb_wd=0, wb_wdata=0, wb_whilo=0 (bubble).
- wb holding a valid write (wb_wreg=1); assert flush=1 together with stall=6'b110000 -> next cycle all outputs 0. Deassert flush -> the next capture proceeds normally.
- mem_whilo=1, hi=0xDEAD0000, lo=0x0000BEEF -> next cycle wb_whilo=1 with the same values. Back-to-back captures over 4 cycles update every cycle with no gaps.
